// File: rtl/uart_pkg.sv
// Shared types and constants for the UART subsystem.
// Holds the arbiter state encoding and the default data width.
package uart_pkg;

    localparam int ANCHO_DEF = 8;

    typedef logic [7:0] contador_t;

    typedef enum logic [1:0] {
        REPOSO,
        INICIO,
        ESPERA_OCUPADO,
        TRANSMITIENDO
    } estado_arbitro_t;

endpackage

// File: rtl/arbitro_tx_uart_mux.sv
// Plain 2:1 data selector.
// The arbiter uses it to steer the winning requester's byte.
module mux_2_a_1
    import uart_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
    input  logic [ANCHO-1:0] dato0_i,
    input  logic [ANCHO-1:0] dato1_i,
    input  logic             seleccion_i,
    output logic [ANCHO-1:0] dato_o
);

    assign dato_o = seleccion_i ? dato1_i : dato0_i;

endmodule

// File: rtl/arbitro_tx_uart.sv
// Round-robin arbiter for two byte producers sharing one UART transmitter.
// It grants one byte, pulses start/ack, then follows the TX busy flag.
module arbitro_tx_uart
    import uart_pkg::*;
#(
    parameter int ANCHO      = ANCHO_DEF,
    parameter int ESPERA_MAX = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_i,
    input  logic [ANCHO-1:0] dato0_i,
    output logic             ack0_o,
    input  logic             req1_i,
    input  logic [ANCHO-1:0] dato1_i,
    output logic             ack1_o,
    input  logic             tx_ocupado_i,
    output logic             tx_inicio_o,
    output logic [ANCHO-1:0] tx_dato_o,
    output logic             seleccion_o,
    output logic             ocupado_o,
    output logic             error_o
);

    localparam contador_t LIMITE = contador_t'(ESPERA_MAX - 1);

    estado_arbitro_t estado_q, estado_d;
    contador_t       contador_q, contador_d;
    logic            ultimo_q, ultimo_d;
    logic            seleccion_q, seleccion_d;
    logic [ANCHO-1:0] txDato_q, txDato_d;
    logic            txInicio_q, txInicio_d;
    logic            ack0_q, ack0_d;
    logic            ack1_q, ack1_d;
    logic            error_q, error_d;
    logic            ganador;
    logic [ANCHO-1:0] datoMux;

    // On a tie the requester that did not win last time gets the grant.
    assign ganador = (req0_i && req1_i) ? ~ultimo_q : req1_i;

    mux_2_a_1 #(
        .ANCHO (ANCHO)
    ) uMux (
        .dato0_i     (dato0_i),
        .dato1_i     (dato1_i),
        .seleccion_i (ganador),
        .dato_o      (datoMux)
    );

    always_comb begin
        estado_d    = estado_q;
        contador_d  = contador_q;
        ultimo_d    = ultimo_q;
        seleccion_d = seleccion_q;
        txDato_d    = txDato_q;
        txInicio_d  = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        error_d     = 1'b0;

        unique case (estado_q)
            REPOSO: begin
                if ((req0_i || req1_i) && !tx_ocupado_i) begin
                    estado_d    = INICIO;
                    ultimo_d    = ganador;
                    seleccion_d = ganador;
                    txDato_d    = datoMux;
                    txInicio_d  = 1'b1;
                    ack0_d      = ~ganador;
                    ack1_d      = ganador;
                end
            end
            INICIO: begin
                contador_d = '0;
                estado_d   = ESPERA_OCUPADO;
            end
            ESPERA_OCUPADO: begin
                if (tx_ocupado_i) begin
                    estado_d = TRANSMITIENDO;
                end else if (contador_q == LIMITE) begin
                    // Ack already went out, so the byte is dropped rather than retried.
                    error_d    = 1'b1;
                    contador_d = '0;
                    estado_d   = REPOSO;
                end else begin
                    contador_d = contador_q + contador_t'(1);
                end
            end
            TRANSMITIENDO: begin
                if (!tx_ocupado_i) begin
                    estado_d = REPOSO;
                end
            end
            default: estado_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            estado_q    <= REPOSO;
            contador_q  <= '0;
            ultimo_q    <= 1'b1;
            seleccion_q <= 1'b0;
            txDato_q    <= '0;
            txInicio_q  <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            contador_q  <= contador_d;
            ultimo_q    <= ultimo_d;
            seleccion_q <= seleccion_d;
            txDato_q    <= txDato_d;
            txInicio_q  <= txInicio_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            error_q     <= error_d;
        end
    end

    assign ack0_o      = ack0_q;
    assign ack1_o      = ack1_q;
    assign tx_inicio_o = txInicio_q;
    assign tx_dato_o   = txDato_q;
    assign seleccion_o = seleccion_q;
    assign error_o     = error_q;
    assign ocupado_o   = (estado_q != REPOSO);

endmodule

// File: tb/tb_arbitro_tx_uart.sv
// Randomized self-checking bench for arbitro_tx_uart.
// Two requester models and a UART busy model drive the DUT; a transfer-level reference predicts outputs.
module tb_arbitro_tx_uart;

    localparam int ANCHO      = 8;
    localparam int ESPERA_MAX = 4;
    localparam int CICLOS     = 3000;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             req0_i;
    logic             req1_i;
    logic [ANCHO-1:0] dato0_i;
    logic [ANCHO-1:0] dato1_i;
    logic             tx_ocupado_i;
    logic             ack0_o;
    logic             ack1_o;
    logic             tx_inicio_o;
    logic [ANCHO-1:0] tx_dato_o;
    logic             seleccion_o;
    logic             ocupado_o;
    logic             error_o;

    int compared   = 0;
    int mismatched = 0;

    // Reference view: a byte is "in flight" from its grant until the UART
    // finishes it or the wait budget for busy runs out.
    bit               mEnVuelo;
    bit               mEnInicio;
    bit               mEsperando;
    int               mEspera;
    bit               mUltimo;
    bit               eAck0;
    bit               eAck1;
    bit               eIni;
    bit               eErr;
    bit               eSel;
    logic [ANCHO-1:0] eDato;

    // UART busy emulation: delay before busy rises and how long it lasts.
    int retardo;
    int largo;

    always #5 clk_i = ~clk_i;

    arbitro_tx_uart #(
        .ANCHO      (ANCHO),
        .ESPERA_MAX (ESPERA_MAX)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_i       (req0_i),
        .dato0_i      (dato0_i),
        .ack0_o       (ack0_o),
        .req1_i       (req1_i),
        .dato1_i      (dato1_i),
        .ack1_o       (ack1_o),
        .tx_ocupado_i (tx_ocupado_i),
        .tx_inicio_o  (tx_inicio_o),
        .tx_dato_o    (tx_dato_o),
        .seleccion_o  (seleccion_o),
        .ocupado_o    (ocupado_o),
        .error_o      (error_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the reference by one clock edge using the inputs seen at that edge.
    task automatic modelStep(input bit rst, input bit r0, input bit r1, input bit busy,
                             input logic [ANCHO-1:0] d0, input logic [ANCHO-1:0] d1);
        bit gana;
        eAck0 = 1'b0;
        eAck1 = 1'b0;
        eIni  = 1'b0;
        eErr  = 1'b0;
        if (rst) begin
            mEnVuelo   = 1'b0;
            mEnInicio  = 1'b0;
            mEsperando = 1'b0;
            mEspera    = 0;
            mUltimo    = 1'b1;
            eSel       = 1'b0;
            eDato      = '0;
        end else if (!mEnVuelo) begin
            if ((r0 || r1) && !busy) begin
                gana      = (r0 && r1) ? !mUltimo : r1;
                mUltimo   = gana;
                eSel      = gana;
                eDato     = gana ? d1 : d0;
                eIni      = 1'b1;
                eAck0     = !gana;
                eAck1     = gana;
                mEnVuelo  = 1'b1;
                mEnInicio = 1'b1;
            end
        end else if (mEnInicio) begin
            mEnInicio  = 1'b0;
            mEsperando = 1'b1;
            mEspera    = 0;
        end else if (mEsperando) begin
            if (busy) begin
                mEsperando = 1'b0;
            end else begin
                mEspera++;
                if (mEspera == ESPERA_MAX) begin
                    eErr       = 1'b1;
                    mEsperando = 1'b0;
                    mEnVuelo   = 1'b0;
                end
            end
        end else if (!busy) begin
            mEnVuelo = 1'b0;
        end
    endtask

    // Drive the next cycle's inputs from the requester and UART behaviours.
    task automatic applyStimulus();
        rst_i = ($urandom_range(0, 79) == 0);

        if (eAck0) begin
            if ($urandom_range(0, 2) == 0) dato0_i = ANCHO'($urandom);
            else                           req0_i  = 1'b0;
        end else if (!req0_i && $urandom_range(0, 3) == 0) begin
            req0_i  = 1'b1;
            dato0_i = ANCHO'($urandom);
        end

        if (eAck1) begin
            if ($urandom_range(0, 2) == 0) dato1_i = ANCHO'($urandom);
            else                           req1_i  = 1'b0;
        end else if (!req1_i && $urandom_range(0, 3) == 0) begin
            req1_i  = 1'b1;
            dato1_i = ANCHO'($urandom);
        end

        if (eIni) begin
            retardo = $urandom_range(0, 6);
            largo   = $urandom_range(1, 5);
        end
        if (retardo > 0) begin
            retardo--;
            tx_ocupado_i = 1'b0;
        end else if (largo > 0) begin
            largo--;
            tx_ocupado_i = 1'b1;
        end else begin
            tx_ocupado_i = ($urandom_range(0, 29) == 0);
        end
    endtask

    initial begin
        rst_i        = 1'b1;
        req0_i       = 1'b1;
        req1_i       = 1'b1;
        dato0_i      = 8'h11;
        dato1_i      = 8'h22;
        tx_ocupado_i = 1'b0;
        retardo      = 0;
        largo        = 0;

        for (int c = 0; c < CICLOS; c++) begin
            @(posedge clk_i);
            modelStep(rst_i, req0_i, req1_i, tx_ocupado_i, dato0_i, dato1_i);
            #1;
            checkOutput("ack0",      32'(ack0_o),      32'(eAck0));
            checkOutput("ack1",      32'(ack1_o),      32'(eAck1));
            checkOutput("tx_inicio", 32'(tx_inicio_o), 32'(eIni));
            checkOutput("error",     32'(error_o),     32'(eErr));
            checkOutput("ocupado",   32'(ocupado_o),   32'(mEnVuelo));
            checkOutput("seleccion", 32'(seleccion_o), 32'(eSel));
            checkOutput("tx_dato",   32'(tx_dato_o),   32'(eDato));
            if (c >= 3) begin
                applyStimulus();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
